// File: rtl/layernorm_ctrl.sv
// layernorm_ctrl: sequencer for a serial layer-normalisation pass over one
// N-element vector.
//
// Flow: LOAD buffers N unsigned elements and accumulates their sum; MEAN
// derives the truncated mean; VAR walks the buffer once, accumulating the
// squared deviations; ISQ hands the variance to a shared inverse-sqrt unit
// over a req/ack handshake; OUT streams the saturated, signed normalised
// elements to the downstream layer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input element handshake, in_data unsigned element
//   out_valid/out_ready output element handshake
//   out_data            signed normalised element
//   out_last            marks element N-1 of the vector
//   isqrt_req/isqrt_arg request and variance operand to the isqrt unit
//   isqrt_ack/isqrt_res isqrt result strobe and 1/sqrt(arg) (FRAC fraction bits)
//   busy                low only while idle in LOAD with nothing buffered
//
// Optional build macro LN_CTRL_PERF_EN adds the performance outputs
//   vec_cnt   vectors completed (wraps)
//   isq_wait  cycles spent waiting in ISQ (saturates)
module layernorm_ctrl #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ISQ_W      = 16,
  parameter int FRAC       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic                    isqrt_req,
  output logic [2*DATA_WIDTH-1:0] isqrt_arg,
  input  logic                    isqrt_ack,
  input  logic [ISQ_W-1:0]        isqrt_res,
  output logic                    busy
`ifdef LN_CTRL_PERF_EN
  ,
  output logic [15:0]             vec_cnt,
  output logic [15:0]             isq_wait
`endif
);

  localparam int LOGN  = $clog2(N);
  localparam int IDXW  = LOGN;
  localparam int SUMW  = DATA_WIDTH + LOGN;
  localparam int SQW   = 2*DATA_WIDTH + LOGN;
  localparam int DEVW  = DATA_WIDTH + 1;
  // Room for a signed deviation times an unsigned inverse root, plus sign.
  localparam int PRODW = DEVW + ISQ_W + 1;

  localparam logic [IDXW-1:0] LAST = IDXW'(N-1);

  localparam logic signed [PRODW-1:0] SAT_MAX =
    {{(PRODW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PRODW-1:0] SAT_MIN =
    {{(PRODW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_LOAD = 3'd0,
    S_MEAN = 3'd1,
    S_VAR  = 3'd2,
    S_ISQ  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t                    state_r;
  logic [IDXW-1:0]           idx_r;
  logic [DATA_WIDTH-1:0]     buf_r [N];
  logic [SUMW-1:0]           sum_r;
  logic [SQW-1:0]            sumsq_r;
  logic [DATA_WIDTH-1:0]     mean_r;
  logic [ISQ_W-1:0]          inv_r;
  logic                      in_ready_r;
  logic                      out_valid_r;
  logic [DATA_WIDTH-1:0]     out_data_r;
  logic                      out_last_r;
  logic                      isqrt_req_r;
  logic [2*DATA_WIDTH-1:0]   isqrt_arg_r;
  logic                      busy_r;

  logic signed [DEVW-1:0]    dev_s;
  logic signed [SQW-1:0]     dev_wide_s;
  logic signed [SQW-1:0]     sq_s;
  logic [SQW-1:0]            sumsq_next_s;
  logic [IDXW-1:0]           idx_inc_s;

  // (elem - mean) * inv >>> FRAC, floored, then clamped to the signed output range.
  function automatic logic [DATA_WIDTH-1:0] norm_elem(
    input logic [DATA_WIDTH-1:0] elem,
    input logic [DATA_WIDTH-1:0] mu,
    input logic [ISQ_W-1:0]      inv
  );
    logic signed [DEVW-1:0]  dev;
    logic signed [PRODW-1:0] prod;
    logic signed [PRODW-1:0] scaled;
    logic [DATA_WIDTH-1:0]   res;
    dev    = $signed({1'b0, elem}) - $signed({1'b0, mu});
    prod   = PRODW'(dev) * $signed(PRODW'({1'b0, inv}));
    scaled = prod >>> FRAC;
    if (scaled > SAT_MAX) begin
      res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (scaled < SAT_MIN) begin
      res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      res = scaled[DATA_WIDTH-1:0];
    end
    return res;
  endfunction

  // Deviation of the addressed element and the running sum of squares.
  // The square is formed at accumulator width; its true value always fits.
  always_comb begin
    dev_s        = $signed({1'b0, buf_r[idx_r]}) - $signed({1'b0, mean_r});
    dev_wide_s   = SQW'(dev_s);
    sq_s         = dev_wide_s * dev_wide_s;
    sumsq_next_s = sumsq_r + $unsigned(sq_s);
    idx_inc_s    = idx_r + IDXW'(1);
  end

  // Main sequencer: state, datapath registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_LOAD;
      idx_r       <= '0;
      sum_r       <= '0;
      sumsq_r     <= '0;
      mean_r      <= '0;
      inv_r       <= '0;
      for (int i = 0; i < N; i++) begin
        buf_r[i] <= '0;
      end
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      isqrt_req_r <= 1'b0;
      isqrt_arg_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        S_LOAD: begin
          if (in_valid && in_ready_r) begin
            buf_r[idx_r] <= in_data;
            sum_r        <= sum_r + SUMW'(in_data);
            busy_r       <= 1'b1;
            if (idx_r == LAST) begin
              idx_r      <= '0;
              in_ready_r <= 1'b0;
              state_r    <= S_MEAN;
            end else begin
              idx_r      <= idx_inc_s;
            end
          end
        end
        S_MEAN: begin
          mean_r  <= sum_r[SUMW-1:LOGN];
          state_r <= S_VAR;
        end
        S_VAR: begin
          sumsq_r <= sumsq_next_s;
          if (idx_r == LAST) begin
            // Variance = sumsq / N, taken from the final accumulation.
            idx_r       <= '0;
            isqrt_arg_r <= sumsq_next_s[SQW-1:LOGN];
            isqrt_req_r <= 1'b1;
            state_r     <= S_ISQ;
          end else begin
            idx_r       <= idx_inc_s;
          end
        end
        S_ISQ: begin
          if (isqrt_ack) begin
            // idx is already 0; the first output uses the fresh result directly.
            inv_r       <= isqrt_res;
            isqrt_req_r <= 1'b0;
            isqrt_arg_r <= '0;
            idx_r       <= '0;
            out_valid_r <= 1'b1;
            out_data_r  <= norm_elem(buf_r[idx_r], mean_r, isqrt_res);
            out_last_r  <= (LAST == '0);
            state_r     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_valid_r && out_ready) begin
            if (idx_r == LAST) begin
              idx_r       <= '0;
              sum_r       <= '0;
              sumsq_r     <= '0;
              out_valid_r <= 1'b0;
              out_data_r  <= '0;
              out_last_r  <= 1'b0;
              in_ready_r  <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= S_LOAD;
            end else begin
              idx_r       <= idx_inc_s;
              out_data_r  <= norm_elem(buf_r[idx_inc_s], mean_r, inv_r);
              out_last_r  <= (idx_inc_s == LAST);
            end
          end
        end
        default: begin
          state_r     <= S_LOAD;
          idx_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          isqrt_req_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign isqrt_req = isqrt_req_r;
  assign isqrt_arg = isqrt_arg_r;
  assign busy      = busy_r;

`ifdef LN_CTRL_PERF_EN
  logic [15:0] vec_cnt_r;
  logic [15:0] isq_wait_r;

  // Performance counters: completed vectors (wrapping) and ISQ wait cycles (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_cnt_r  <= 16'd0;
      isq_wait_r <= 16'd0;
    end else begin
      if ((state_r == S_OUT) && out_valid_r && out_ready && out_last_r) begin
        vec_cnt_r <= vec_cnt_r + 16'd1;
      end
      if ((state_r == S_ISQ) && (isq_wait_r != 16'hFFFF)) begin
        isq_wait_r <= isq_wait_r + 16'd1;
      end
    end
  end

  assign vec_cnt  = vec_cnt_r;
  assign isq_wait = isq_wait_r;
`endif

endmodule

// File: tb/tb_layernorm_ctrl.sv
// tb_layernorm_ctrl: directed bench for layernorm_ctrl (N=4, DATA_WIDTH=8,
// ISQ_W=16, FRAC=8). Expected outputs are pushed to a scoreboard queue when
// a vector is sent and popped by a monitor on each output handshake.
// With LN_CTRL_PERF_EN defined the performance counters are also exercised.
module tb_layernorm_ctrl;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        isqrt_req;
  logic [15:0] isqrt_arg;
  logic        isqrt_ack;
  logic [15:0] isqrt_res;
  logic        busy;
`ifdef LN_CTRL_PERF_EN
  logic [15:0] vec_cnt;
  logic [15:0] isq_wait;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_accept_cyc = 0;
  int   first_valid_cyc = 0;
  bit   rand_ready = 1'b0;
  exp_t sb [$];

  logic       hold_prev = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic       prev_last = 1'b0;

  layernorm_ctrl #(.N(4), .DATA_WIDTH(8), .ISQ_W(16), .FRAC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .isqrt_req (isqrt_req),
    .isqrt_arg (isqrt_arg),
    .isqrt_ack (isqrt_ack),
    .isqrt_res (isqrt_res),
    .busy      (busy)
`ifdef LN_CTRL_PERF_EN
    ,
    .vec_cnt   (vec_cnt),
    .isq_wait  (isq_wait)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream ready: always high, or random while backpressure is enabled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop on handshake plus hold-under-stall checks.
  always @(negedge clk) begin
    exp_t e;
    if (hold_prev) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {24'd0, out_data}, {24'd0, prev_data});
      check("hold_last", {31'd0, out_last}, {31'd0, prev_last});
    end
    if (out_valid && out_ready) begin
      if (sb.size() > 0) e = sb.pop_front();
      else e = 'x;
      check("out_data", {24'd0, out_data}, {24'd0, e.data});
      check("out_last", {31'd0, out_last}, {31'd0, e.last});
      check("in_ready_in_out", {31'd0, in_ready}, 32'd0);
    end
    if (out_valid && !prev_valid) first_valid_cyc = cyc;
    hold_prev  = out_valid && !out_ready;
    prev_valid = out_valid;
    prev_data  = out_data;
    prev_last  = out_last;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    sb.push_back({e0, 1'b0});
    sb.push_back({e1, 1'b0});
    sb.push_back({e2, 1'b0});
    sb.push_back({e3, 1'b1});
  endtask

  task automatic send_vector(input logic [7:0] v0, input logic [7:0] v1,
                             input logic [7:0] v2, input logic [7:0] v3, input bit gaps);
    logic [7:0] v [4];
    bit acc;
    int g;
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = v[i];
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      check("in_accept", {31'd0, acc}, 32'd1);
    end
    last_accept_cyc = cyc;
  endtask

  task automatic serve_isqrt(input int d, input logic [15:0] res,
                             input logic [15:0] exp_arg, input bit junk);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = isqrt_req;
    end
    check("isqrt_req_rise", {31'd0, seen}, 32'd1);
    check("isqrt_arg", {16'd0, isqrt_arg}, {16'd0, exp_arg});
    check("busy_isq", {31'd0, busy}, 32'd1);
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'd99;
    end
    for (int k = 0; k < d; k++) begin
      @(negedge clk);
      check("isqrt_req_hold", {31'd0, isqrt_req}, 32'd1);
      check("isqrt_arg_hold", {16'd0, isqrt_arg}, {16'd0, exp_arg});
      check("in_ready_isq", {31'd0, in_ready}, 32'd0);
    end
    isqrt_ack = 1'b1;
    isqrt_res = res;
    @(posedge clk);
    #1;
    isqrt_ack = 1'b0;
    isqrt_res = 16'd0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("isqrt_req_drop", {31'd0, isqrt_req}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() > 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("sb_drained", sb.size(), 32'd0);
    @(negedge clk);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    check("out_valid_idle", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    isqrt_ack = 1'b0;
    isqrt_res = 16'd0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_isqrt_req", {31'd0, isqrt_req}, 32'd0);
    check("rst_isqrt_arg", {16'd0, isqrt_arg}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // Scenario 1: 10,20,30,40, ack two cycles after req, res=23
    send_vector(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    push_exp(8'hFE, 8'hFF, 8'h00, 8'h01);
    serve_isqrt(2, 16'd23, 16'd125, 1'b0);
    drain();
    check("latency_s1", first_valid_cyc - last_accept_cyc, 32'd8);

    // Scenario 2: constant vector, immediate ack; stray in_valid during ISQ
    send_vector(8'd7, 8'd7, 8'd7, 8'd7, 1'b0);
    push_exp(8'h00, 8'h00, 8'h00, 8'h00);
    serve_isqrt(0, 16'd4095, 16'd0, 1'b1);
    drain();
    check("latency_s2", first_valid_cyc - last_accept_cyc, 32'd6);

    // Scenario 3: saturation
    send_vector(8'd0, 8'd0, 8'd0, 8'd255, 1'b0);
    push_exp(8'h80, 8'h80, 8'h80, 8'h7F);
    serve_isqrt(1, 16'd4096, 16'd12192, 1'b0);
    drain();

    // Backpressure: input gaps and random out_ready
    rand_ready = 1'b1;
    send_vector(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    push_exp(8'hFE, 8'hFF, 8'h00, 8'h01);
    serve_isqrt(3, 16'd23, 16'd125, 1'b0);
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset during ISQ, late ack after reset must be ignored
    send_vector(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = isqrt_req;
    end
    check("abort_req_seen", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_req_low", {31'd0, isqrt_req}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    isqrt_ack = 1'b1;
    isqrt_res = 16'd23;
    @(posedge clk);
    #1;
    isqrt_ack = 1'b0;
    isqrt_res = 16'd0;
    @(negedge clk);
    check("late_ack_out_valid", {31'd0, out_valid}, 32'd0);
    check("late_ack_req", {31'd0, isqrt_req}, 32'd0);
    check("late_ack_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send_vector(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    push_exp(8'hFE, 8'hFF, 8'h00, 8'h01);
    serve_isqrt(2, 16'd23, 16'd125, 1'b0);
    drain();

`ifdef LN_CTRL_PERF_EN
    // Performance counters over three vectors with ack delays 0, 2, 5
    do_reset();
    send_vector(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    push_exp(8'hFE, 8'hFF, 8'h00, 8'h01);
    serve_isqrt(0, 16'd23, 16'd125, 1'b0);
    drain();
    send_vector(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    push_exp(8'hFE, 8'hFF, 8'h00, 8'h01);
    serve_isqrt(2, 16'd23, 16'd125, 1'b0);
    drain();
    send_vector(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    push_exp(8'hFE, 8'hFF, 8'h00, 8'h01);
    serve_isqrt(5, 16'd23, 16'd125, 1'b0);
    drain();
    @(negedge clk);
    check("perf_vec_cnt", {16'd0, vec_cnt}, 32'd3);
    check("perf_isq_wait", {16'd0, isq_wait}, 32'd10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layernorm_ctrl.md
Name: layernorm_ctrl

Overview:
- Sequencer for a serial layer-normalisation pass over one N-element vector.
- Buffers the vector while accumulating the sum, then computes the mean and the variance over the buffered data.
- Obtains 1/sqrt(var) from a shared inverse-sqrt unit through a req/ack handshake, then streams out normalised elements.
- Sits between the token input stream and the downstream layer; the isqrt unit is external and shared.

Parameters:
- N, 4, vector length; power of two, >= 2.
- DATA_WIDTH, 8, input element width (unsigned) and output element width (signed).
- ISQ_W, 16, width of the isqrt result (unsigned Q-format).
- FRAC, 8, fractional bits of the isqrt result.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input element valid
- in_ready  out  1  block accepts an input element
- in_data  in  DATA_WIDTH  unsigned input element
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accepts the output element
- out_data  out  DATA_WIDTH  signed normalised element
- out_last  out  1  marks element N-1 of the vector
- isqrt_req  out  1  request to the shared isqrt unit
- isqrt_arg  out  2*DATA_WIDTH  variance operand
- isqrt_ack  in  1  isqrt result valid
- isqrt_res  in  ISQ_W  1/sqrt(arg), FRAC fractional bits
- busy  out  1  high in every state except LOAD with idx==0

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset state: LOAD, idx=0, sum=0, sumsq=0. All outputs are 0 except in_ready=1.
- Reset mid-operation aborts the vector, returns to this reset state, and drops isqrt_req on the next cycle.
- FSM: LOAD -> MEAN -> VAR -> ISQ -> OUT -> LOAD.
- LOAD
  - in_ready=1.
  - On each in_valid&in_ready: buf[idx]<=in_data, sum+=in_data, idx++.
  - After the N-th accept: idx<=0, go to MEAN.
- MEAN
  - 1 cycle: mean <= sum >> log2(N), truncating; sum width is DATA_WIDTH+log2(N).
- VAR
  - N cycles, one element per cycle: dev = buf[idx]-mean, signed DATA_WIDTH+1 bits; sumsq += dev*dev.
  - Full-width accumulation, no overflow possible.
  - Leaving VAR: var <= sumsq >> log2(N), truncated to 2*DATA_WIDTH bits (always fits). Go to ISQ.
- ISQ
  - isqrt_req=1 and isqrt_arg=var, both stable until isqrt_ack is sampled high.
  - Ack may arrive in the first req cycle.
  - On ack: inv <= isqrt_res, isqrt_req <= 0 on the next cycle, idx<=0, go to OUT.
  - isqrt_ack is ignored in all other states.
- OUT
  - out_valid=1, out_data = sat((buf[idx]-mean)*inv >>> FRAC), where >>> is an arithmetic shift (floor).
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - out_last = (idx==N-1).
  - out_data and out_last hold while out_ready=0.
  - On handshake: idx++. After the last handshake: clear sum and sumsq, go to LOAD.
  - out_data is registered; in_ready=0 during OUT.
- Latency with no stalls: last input accept to first out_valid = N+2+ack_delay cycles, where ack_delay counts cycles from isqrt_req rise to isqrt_ack.
- var==0: still issues the request; the result is used as returned. Output is 0 because dev=0.
- in_valid while not in LOAD: not accepted, no side effect.

Optional Feature:
- Macro: LN_CTRL_PERF_EN.
- Defined:
  - Adds output vec_cnt [15:0], incremented on each out_last handshake and wrapping at 0xFFFF->0.
  - Adds output isq_wait [15:0], counting total cycles spent in ISQ and saturating at 0xFFFF.
  - Both are cleared by rst.
- Undefined: neither port exists, and no counter logic is built.

Test Plan:
- N=4, DATA_WIDTH=8, FRAC=8. Input 10,20,30,40; ack 2 cycles after req with res=23.
  - Required: isqrt_arg=125; outputs -2,-1,0,1; out_last only on the 4th.
- Input 7,7,7,7; ack immediately with res=4095.
  - Required: isqrt_arg=0; outputs 0,0,0,0.
- Input 0,0,0,255; res=4096.
  - Required: mean=63, isqrt_arg=12192; outputs -128,-128,-128,127 (saturated).
- Backpressure:
  - Random in_valid gaps and out_ready toggling.
  - Required: no element lost or duplicated; out_data stable while out_valid&!out_ready; results identical to scenario 1.
- Reset mid-operation:
  - Assert rst during ISQ, then pulse isqrt_ack one cycle after rst falls.
  - Required: isqrt_req=0 and in_ready=1 on the cycle after rst; late ack ignored; next vector 10,20,30,40 produces scenario 1 outputs.
- LN_CTRL_PERF_EN defined:
  - Run 3 vectors with ack delays 0, 2 and 5.
  - Required: vec_cnt=3, isq_wait=10 (1+3+6).
